// File: rtl/execute_ctrl_if.sv
// Decode/execute control bundle between the pipeline datapath and execute_ctrl.
// The datapath side (master) drives decode/execute status; the controller (slave) drives decisions.
interface execute_ctrl_if;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        mem_ready;
  logic        branch_resolve;
  logic        branch_taken;
  logic        branch_predicted_taken;
  logic        ex_issue;
  logic        stall_out;
  logic        flush_out;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [1:0]  state_out;
  logic [31:0] stall_count;
  logic [15:0] flush_count;

  // Handshake: mem_ready=1 means memory takes execute's result on this edge; while it is
  // low, execute holds (stall_out=1) and no instruction issues (ex_issue=0).
  modport master (
    output id_valid, id_opcode, id_funct7, id_rs1, id_rs2, ex_rd, ex_is_load,
           mem_ready, branch_resolve, branch_taken, branch_predicted_taken,
    input  ex_issue, stall_out, flush_out, muldiv_busy, muldiv_done, state_out,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_opcode, id_funct7, id_rs1, id_rs2, ex_rd, ex_is_load,
           mem_ready, branch_resolve, branch_taken, branch_predicted_taken,
    output ex_issue, stall_out, flush_out, muldiv_busy, muldiv_done, state_out,
           stall_count, flush_count
  );
endinterface

// File: rtl/execute_ctrl.sv
// Execute-stage sequencer: issue/stall/flush decisions, mul/div occupancy tracking
// and stall/flush performance counters.
module execute_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int FLUSH_CYCLES  = 2
) (
  input logic           req,
  input logic           rst_n,
  execute_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [5:0] MULDIV_LOAD = 6'(MULDIV_CYCLES - 1);
  localparam logic [5:0] FLUSH_LOAD  = 6'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] stall_count_q;
  logic [15:0] flush_count_q;

  logic mispredict;
  logic uses_rs2;
  logic hazard;
  logic is_muldiv;
  logic stall_c;
  logic issue_c;
  logic done_c;

  assign mispredict = bus.branch_resolve & (bus.branch_taken ^ bus.branch_predicted_taken);
  assign uses_rs2   = (bus.id_opcode == OP_REG) | (bus.id_opcode == OP_STORE) |
                      (bus.id_opcode == OP_BRANCH);
  // x0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign hazard     = bus.id_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                      ((bus.id_rs1 == bus.ex_rd) | (uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign is_muldiv  = (bus.id_opcode == OP_REG) & (bus.id_funct7 == F7_MULDIV);

  // Decision chain in priority order; everything is forced low while in reset.
  always_comb begin
    stall_c = 1'b0;
    issue_c = 1'b0;
    done_c  = 1'b0;
    if (rst_n && !mispredict && (state != ST_FLUSH)) begin
      if (!bus.mem_ready) begin
        stall_c = 1'b1;
      end else if (state == ST_MULDIV) begin
        if (cnt == 6'd0) begin
          done_c = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end else if (hazard) begin
        stall_c = 1'b1;
      end else begin
        issue_c = bus.id_valid;
      end
    end
  end

  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= 6'd0;
    end else if (mispredict) begin
      // A new misprediction restarts the flush window, even mid mul/div.
      state <= ST_FLUSH;
      cnt   <= FLUSH_LOAD;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (cnt == 6'd0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        ST_MULDIV: begin
          if (bus.mem_ready) begin
            if (cnt == 6'd0) begin
              state <= ST_RUN;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end
        default: begin
          if (issue_c && is_muldiv) begin
            state <= ST_MULDIV;
            cnt   <= MULDIV_LOAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 16'd0;
    end else begin
      if (stall_c) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (mispredict) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign bus.ex_issue    = issue_c;
  assign bus.stall_out   = stall_c;
  assign bus.muldiv_done = done_c;
  assign bus.flush_out   = (state == ST_FLUSH);
  assign bus.muldiv_busy = (state == ST_MULDIV);
  assign bus.state_out   = state;
  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;

endmodule

// File: doc/execute_ctrl.md
Name: execute_ctrl

Overview:
- Pipeline controller that sequences the execute stage.
- Decides each cycle whether the decoded instruction issues into execute, stalls, or is flushed.
- Stall causes: load-use hazards, memory backpressure, multi-cycle RV32M mul/div occupancy.
- Flush cause: branch mispredictions resolved in execute. Drives execute's stall input and the fetch/decode flush, and keeps stall/flush performance counters.

Parameters:
- MULDIV_CYCLES, 32, execute occupancy of one mul/div op in cycles; legal range 2..64.
- FLUSH_CYCLES, 2, cycles flush_out stays high after a misprediction; legal range 1..4.

Ports:
- req  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_opcode  in  7  decoded opcode
- id_funct7  in  7  decoded funct7
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- ex_rd  in  5  destination of instruction currently in execute
- ex_is_load  in  1  instruction in execute is a load (opcode 0000011)
- mem_ready  in  1  memory stage accepts execute's result this cycle
- branch_resolve  in  1  execute resolves a branch/jump this cycle
- branch_taken  in  1  actual outcome
- branch_predicted_taken  in  1  predicted outcome
- ex_issue  out  1  instruction enters execute on next edge
- stall_out  out  1  hold fetch/decode/execute registers
- flush_out  out  1  kill fetch/decode contents
- muldiv_busy  out  1  mul/div occupying execute
- muldiv_done  out  1  one-cycle pulse, last mul/div cycle
- state_out  out  2  0=RUN, 1=MULDIV, 2=FLUSH
- stall_count  out  32  cycles with stall_out=1, wraps
- flush_count  out  16  mispredictions detected, wraps

Behaviour:
- Reset (async, any state, mid-op included): state=RUN, counter=0, both perf counters=0, flush_out=0, muldiv_busy=0, muldiv_done=0. Combinational outputs fall to 0 while rst_n=0.
- Mispredict: mispredict = branch_resolve & (branch_taken ^ branch_predicted_taken).
- Load-use hazard: hazard = id_valid & ex_is_load & ex_rd!=0 & (id_rs1==ex_rd | (uses_rs2 & id_rs2==ex_rd)).
  - uses_rs2 is true for opcodes 0110011, 0100011, 1100011.
  - x0 never hazards.
- Mul/div detection: is_muldiv = id_opcode==0110011 & id_funct7==0000001.
- Priority, highest first: rst_n, mispredict, state FLUSH, mem_ready=0, state MULDIV, hazard.
- RUN state:
  - mispredict -> FLUSH; counter=FLUSH_CYCLES-1; ex_issue=0.
  - mem_ready=0 -> stall_out=1, ex_issue=0, stay.
  - hazard -> stall_out=1, ex_issue=0 (one bubble). Condition clears next cycle once the load leaves execute.
  - Otherwise ex_issue=id_valid, stall_out=0.
  - ex_issue & is_muldiv -> MULDIV; counter=MULDIV_CYCLES-1.
- MULDIV state:
  - muldiv_busy=1, stall_out=1, ex_issue=0.
  - Counter decrements only when mem_ready=1.
  - muldiv_done=1 in the cycle counter==0 & mem_ready; next state RUN; stall_out=0 that cycle so decode may issue.
  - Latency from issue edge to RUN: MULDIV_CYCLES cycles with no backpressure.
- FLUSH state:
  - flush_out=1, stall_out=0, ex_issue=0.
  - Counter decrements each cycle; at 0 -> RUN. flush_out is high exactly FLUSH_CYCLES cycles.
  - mispredict while in FLUSH reloads the counter; flush_count still increments.
- flush_out is registered (state-derived). stall_out, ex_issue and muldiv_done are combinational from state, counter and inputs.
- Perf counters:
  - stall_count += 1 on each edge with stall_out=1.
  - flush_count += 1 on each edge with mispredict.
  - Both wrap (0xFFFFFFFF -> 0; 0xFFFF -> 0).
- Simultaneous mispredict & hazard: flush wins, no stall counted.
- Simultaneous mem_ready=0 & hazard: single stall cycle counted once.

Test Plan:
- Reset then id_valid=1, add (0110011/0000000) -> ex_issue=1, stall_out=0, state_out=0, counters 0.
- ex_is_load=1, ex_rd=5, id_rs1=5 -> stall_out=1, ex_issue=0 for one cycle, stall_count=1. Repeat with ex_rd=0 -> no stall.
- Issue mul (funct7=0000001), MULDIV_CYCLES=32, mem_ready=1 -> muldiv_busy high 32 cycles, muldiv_done pulses on the 32nd, then RUN.
  - Add mem_ready=0 for 3 mid-op cycles -> busy extends to 35 cycles.
- branch_resolve=1, taken=1, predicted=0 -> flush_out high exactly 2 cycles, flush_count=1.
  - Second mispredict in the first flush cycle -> flush_out high 3 cycles total, flush_count=2.
- Mid-MULDIV drop rst_n asynchronously (between edges) -> state_out=0, muldiv_busy=0, stall_count=0 immediately, before the next req edge.
- Preload near-wrap via 2^32 stall cycles, or force in sim -> stall_count wraps 0xFFFFFFFF -> 0.
